// File: rtl/lif_neuron_array.sv
// Serial leaky integrate-and-fire stage: updates N membrane potentials one per cycle and emits a spike vector.
// Optional LIF_VPROBE_EN adds a registered membrane-potential probe port (probe_sel / probe_v).
module lif_neuron_array #(
  parameter int N            = 256,
  parameter int IN_WIDTH     = 40,
  parameter int V_WIDTH      = 32,
  parameter int LEAK_SHIFT   = 4,
  parameter int V_THRESH     = 1024,
  parameter int V_RESET      = 0,
  parameter int REFRAC_STEPS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cur_valid,
  output logic                  cur_ready,
  input  logic [N*IN_WIDTH-1:0] cur_in,
  output logic                  spk_valid,
  input  logic                  spk_ready,
  output logic [N-1:0]          spk_out,
  output logic                  busy
`ifdef LIF_VPROBE_EN
  ,
  input  logic [$clog2(N)-1:0]  probe_sel,
  output logic [V_WIDTH-1:0]    probe_v
`endif
);

  // state  | meaning
  // IDLE   | waiting for a current vector, cur_ready high
  // UPDATE | one neuron per cycle, then one cycle to publish the shadow spikes
  // OUTPUT | spike vector held valid until spk_ready

  localparam int KW = $clog2(N);
  localparam int XW = KW + 1;
  localparam int RW = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

  localparam logic [XW-1:0]             IDX_DONE    = XW'(N);
  localparam logic signed [V_WIDTH-1:0] V_MAX       = {1'b0, {(V_WIDTH-1){1'b1}}};
  localparam logic signed [V_WIDTH-1:0] V_MIN       = {1'b1, {(V_WIDTH-1){1'b0}}};
  localparam logic signed [V_WIDTH-1:0] THRESH      = V_WIDTH'(V_THRESH);
  localparam logic signed [V_WIDTH-1:0] V_RST       = V_WIDTH'(V_RESET);
  localparam logic [RW-1:0]             REFRAC_INIT = RW'(REFRAC_STEPS);

  typedef enum logic [1:0] {IDLE, UPDATE, OUTPUT} state_t;

  state_t                     state;
  logic signed [V_WIDTH-1:0]  v [N];
  logic [RW-1:0]              refrac [N];
  logic [N*IN_WIDTH-1:0]      cur_reg;
  logic [N-1:0]               shadow;
  logic [XW-1:0]              idx;
  logic [KW-1:0]              k;

  logic signed [IN_WIDTH-1:0] i_raw;
  logic signed [V_WIDTH-1:0]  i_sat, v_cur, leak, v_sat, v_new;
  logic signed [V_WIDTH:0]    v_sum;
  logic [RW-1:0]              r_cur, r_new;
  logic                       fire;

  assign k     = idx[KW-1:0];
  assign i_raw = cur_reg[k*IN_WIDTH +: IN_WIDTH];

  generate
    if (IN_WIDTH > V_WIDTH) begin : g_clamp
      localparam logic signed [IN_WIDTH-1:0] I_MAX = {{(IN_WIDTH-V_WIDTH+1){1'b0}}, {(V_WIDTH-1){1'b1}}};
      localparam logic signed [IN_WIDTH-1:0] I_MIN = {{(IN_WIDTH-V_WIDTH+1){1'b1}}, {(V_WIDTH-1){1'b0}}};
      always_comb begin
        if (i_raw > I_MAX)      i_sat = V_MAX;
        else if (i_raw < I_MIN) i_sat = V_MIN;
        else                    i_sat = i_raw[V_WIDTH-1:0];
      end
    end else begin : g_ext
      assign i_sat = V_WIDTH'(i_raw);
    end
  endgenerate

  // One extra bit holds any leak+input overflow so it can be saturated instead of wrapping.
  always_comb begin
    v_cur = v[k];
    r_cur = refrac[k];
    leak  = v_cur >>> LEAK_SHIFT;
    v_sum = {v_cur[V_WIDTH-1], v_cur} - {leak[V_WIDTH-1], leak} + {i_sat[V_WIDTH-1], i_sat};
    if (v_sum[V_WIDTH] != v_sum[V_WIDTH-1]) v_sat = v_sum[V_WIDTH] ? V_MIN : V_MAX;
    else                                    v_sat = v_sum[V_WIDTH-1:0];
    fire  = 1'b0;
    v_new = v_sat;
    r_new = r_cur;
    if (r_cur != '0) begin
      v_new = V_RST;
      r_new = r_cur - 1'b1;
    end else if (v_sat >= THRESH) begin
      fire  = 1'b1;
      v_new = V_RST;
      r_new = REFRAC_INIT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      cur_reg   <= '0;
      shadow    <= '0;
      spk_out   <= '0;
      spk_valid <= 1'b0;
      cur_ready <= 1'b1;
      busy      <= 1'b0;
      for (int i = 0; i < N; i++) begin
        v[i]      <= V_RST;
        refrac[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (cur_valid) begin
            cur_reg   <= cur_in;
            idx       <= '0;
            cur_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= UPDATE;
          end
        end
        UPDATE: begin
          if (idx == IDX_DONE) begin
            spk_out   <= shadow;
            spk_valid <= 1'b1;
            state     <= OUTPUT;
          end else begin
            v[k]      <= v_new;
            refrac[k] <= r_new;
            shadow[k] <= fire;
            idx       <= idx + 1'b1;
          end
        end
        OUTPUT: begin
          if (spk_ready) begin
            spk_valid <= 1'b0;
            busy      <= 1'b0;
            cur_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LIF_VPROBE_EN
  // Reads the stored value, so a neuron written this cycle returns its pre-update potential.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) probe_v <= '0;
    else       probe_v <= v[probe_sel];
  end
`endif

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array (N=4) with a behavioural LIF model feeding a spike scoreboard.
// Build with or without LIF_VPROBE_EN; probe checks only exist when the macro is defined.
module tb_lif_neuron_array;
  localparam int N  = 4;
  localparam int IW = 40;
  localparam int VW = 32;
  localparam longint VMAX = 64'sd2147483647;
  localparam longint VMIN = -64'sd2147483648;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            cur_valid = 1'b0;
  logic            spk_ready = 1'b1;
  logic [N*IW-1:0] cur_in = '0;
  logic            cur_ready, spk_valid, busy;
  logic [N-1:0]    spk_out;
`ifdef LIF_VPROBE_EN
  logic [1:0]      probe_sel = '0;
  logic [VW-1:0]   probe_v;
`endif

  lif_neuron_array #(.N(N), .IN_WIDTH(IW), .V_WIDTH(VW), .LEAK_SHIFT(4), .V_THRESH(1024),
                     .V_RESET(0), .REFRAC_STEPS(2)) dut (
    .clk(clk), .reset(reset), .cur_valid(cur_valid), .cur_ready(cur_ready), .cur_in(cur_in),
    .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_out(spk_out), .busy(busy)
`ifdef LIF_VPROBE_EN
    , .probe_sel(probe_sel), .probe_v(probe_v)
`endif
  );

  always #5 clk = ~clk;

  int           vectors = 0;
  int           miscompares = 0;
  logic [N-1:0] sb[$];
  longint       cv[N];
  longint       mv[N];
  int           mr[N];
  logic [N-1:0] held;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint clamp(input longint x);
    return (x > VMAX) ? VMAX : ((x < VMIN) ? VMIN : x);
  endfunction

  function automatic logic [N-1:0] model_step();
    logic [N-1:0] s = '0;
    for (int n = 0; n < N; n++) begin
      longint nx;
      if (mr[n] > 0) begin
        mv[n] = 0;
        mr[n]--;
      end else begin
        nx = clamp(mv[n] - (mv[n] >>> 4) + clamp(cv[n]));
        if (nx >= 1024) begin
          s[n]  = 1'b1;
          mv[n] = 0;
          mr[n] = 2;
        end else mv[n] = nx;
      end
    end
    return s;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < N; n++) begin
      mv[n] = 0;
      mr[n] = 0;
      cv[n] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cur_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    model_reset();
  endtask

  task automatic launch();
    int w = 0;
    @(negedge clk);
    while (!cur_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk("ready_timeout", 64'(w), 64'd0);
    for (int n = 0; n < N; n++) cur_in[n*IW +: IW] = cv[n][IW-1:0];
    cur_valid = 1'b1;
    sb.push_back(model_step());
    @(posedge clk);
    @(negedge clk);
    cur_valid = 1'b0;
    chk("cur_ready_busy", 64'(cur_ready), 64'd0);
    chk("busy_update", 64'(busy), 64'd1);
  endtask

  task automatic wait_out(input bit chk_lat);
    int k = 0;
    while (!spk_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (chk_lat) chk("latency", 64'(k), 64'(N + 1));
    else         chk("spk_valid", 64'(spk_valid), 64'd1);
    if (sb.size() == 0) chk("sb_empty", 64'd1, 64'd0);
    else                chk("spk_out", 64'(spk_out), 64'(sb.pop_front()));
  endtask

  task automatic run_step(input bit chk_lat);
    launch();
    wait_out(chk_lat);
  endtask

  initial begin
    model_reset();
    do_reset();
    chk("rst_spk_out", 64'(spk_out), 64'd0);
    chk("rst_spk_valid", 64'(spk_valid), 64'd0);
    chk("rst_cur_ready", 64'(cur_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);

    // basic spike and accept-to-valid latency
    cv[3] = 2000;
    run_step(1'b1);
    chk("t1_pattern", 64'(spk_out), 64'b1000);

    // integrate-and-leak ramp on neuron 0
    do_reset();
    cv[0] = 512;
    for (int s = 0; s < 3; s++) begin
      run_step(1'b0);
      chk("t2_bit0", 64'(spk_out[0]), 64'(s == 2));
    end
`ifdef LIF_VPROBE_EN
    probe_sel = 2'd0;
    @(negedge clk);
    chk("t2_probe_v0", 64'(probe_v), 64'(mv[0][VW-1:0]));
`endif

    // refractory spacing on neuron 1
    do_reset();
    cv[1] = 5000;
    for (int s = 1; s <= 7; s++) begin
      run_step(1'b0);
      chk("t3_bit1", 64'(spk_out[1]), 64'(s == 1 || s == 4 || s == 7));
    end

    // input and potential saturation on neuron 2
    do_reset();
    cv[2] = 64'sd549755813887;
    run_step(1'b0);
    chk("t4_pos_sat", 64'(spk_out[2]), 64'd1);
    cv[2] = -64'sd549755813888;
    for (int s = 0; s < 4; s++) run_step(1'b0);
`ifdef LIF_VPROBE_EN
    probe_sel = 2'd2;
    @(negedge clk);
    chk("t4_probe_min", 64'(probe_v), 64'h8000_0000);
`endif
    cv[2] = 0;
    run_step(1'b0);
    chk("t4_no_wrap", 64'(spk_out[2]), 64'd0);

    // output stall with upstream holding a vector
    do_reset();
    spk_ready = 1'b0;
    run_step(1'b0);
    held = spk_out;
    for (int n = 0; n < N; n++) cur_in[n*IW +: IW] = (n == 0) ? 40'd2000 : 40'd0;
    cur_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("t5_cur_ready", 64'(cur_ready), 64'd0);
      chk("t5_spk_stable", 64'(spk_out), 64'(held));
      chk("t5_spk_valid", 64'(spk_valid), 64'd1);
    end
    cur_valid = 1'b0;
    spk_ready = 1'b1;
    @(negedge clk);
    chk("t5_release_valid", 64'(spk_valid), 64'd0);
    chk("t5_release_ready", 64'(cur_ready), 64'd1);
    cv[0] = 1000;
    run_step(1'b0);
    run_step(1'b0);
    chk("t5_no_second_accept", 64'(spk_out[0]), 64'd1);

    // reset in the middle of an update
    do_reset();
    cv[0] = 512;
    cv[1] = 512;
    run_step(1'b0);
    cv[0] = 400;
    cv[1] = 400;
    launch();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t6_spk_valid", 64'(spk_valid), 64'd0);
    chk("t6_cur_ready", 64'(cur_ready), 64'd1);
    chk("t6_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    model_reset();
`ifdef LIF_VPROBE_EN
    for (int n = 0; n < N; n++) begin
      probe_sel = 2'(n);
      @(negedge clk);
      chk("t6_probe_zero", 64'(probe_v), 64'd0);
    end
`endif
    cv[0] = 600;
    cv[1] = 600;
    run_step(1'b1);
    chk("t6_v_cleared", 64'(spk_out), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
